// File: rtl/spi_controller.sv
// SPI mode-0 target that streams a byte-addressed memory out on cipo, MSB first, from address 0.
// Define SPI_CONTROLLER_WRAP_EN to wrap data_address to 0 after DEPTH-1; otherwise it holds at DEPTH-1.
module spi_controller #(
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 16384
) (
  input  logic                  sck,
  input  logic                  reset,
  input  logic                  cs,
  input  logic [7:0]            data,
  output logic                  cipo,
  output logic [ADDR_WIDTH-1:0] data_address,
  output logic [2:0]            bit_index,
  output logic [15:0]           byte_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic                  clr;
  logic [ADDR_WIDTH-1:0] next_address;

  // Dropping chip select clears transfer state just like reset, so a partial byte is discarded.
  assign clr = reset | ~cs;

  always_comb begin
    next_address = data_address + 1'b1;
    if (data_address == LAST_ADDR) begin
`ifdef SPI_CONTROLLER_WRAP_EN
      next_address = '0;
`else
      next_address = data_address;
`endif
    end
  end

  always_ff @(negedge sck or posedge clr) begin
    if (clr) begin
      bit_index    <= 3'd0;
      data_address <= '0;
      byte_count   <= 16'd0;
    end else if (bit_index == 3'd7) begin
      bit_index    <= 3'd0;
      data_address <= next_address;
      if (byte_count != 16'hFFFF) begin
        byte_count <= byte_count + 16'd1;
      end
    end else begin
      bit_index <= bit_index + 3'd1;
    end
  end

  // Combinational so bit 7 of byte 0 is on the wire as soon as cs rises.
  assign cipo = clr ? 1'b0 : data[3'd7 - bit_index];

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: a default-depth instance and a DEPTH=4 instance share one SPI bus.
`timescale 1ns/1ps
module tb_spi_controller;

  logic        sck;
  logic        reset;
  logic        cs;
  logic [7:0]  data_main;
  logic [7:0]  data4;
  logic        cipo;
  logic        cipo4;
  logic [13:0] data_address;
  logic [1:0]  data_address4;
  logic [2:0]  bit_index;
  logic [2:0]  bit_index4;
  logic [15:0] byte_count;
  logic [15:0] byte_count4;

  logic [7:0]  mem [0:15];
  logic [7:0]  exp4 [0:5];
  logic [7:0]  s_main;
  logic [7:0]  s4;
  logic [1:0]  exp_addr4;
  int          n_cmp;
  int          n_err;

  assign data_main = mem[data_address[3:0]];
  assign data4     = mem[{2'b00, data_address4}];

  spi_controller dut (
    .sck(sck), .reset(reset), .cs(cs), .data(data_main), .cipo(cipo),
    .data_address(data_address), .bit_index(bit_index), .byte_count(byte_count)
  );

  spi_controller #(.ADDR_WIDTH(2), .DEPTH(4)) dut4 (
    .sck(sck), .reset(reset), .cs(cs), .data(data4), .cipo(cipo4),
    .data_address(data_address4), .bit_index(bit_index4), .byte_count(byte_count4)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One 1 MHz sck period; the host samples cipo in the low phase just before the rising edge.
  task automatic clk_bit();
    #250;
    s_main = {s_main[6:0], cipo};
    s4     = {s4[6:0], cipo4};
    #250 sck = 1'b1;
    #500 sck = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    s_main = 8'h00;
    s4 = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
`ifdef SPI_CONTROLLER_WRAP_EN
    exp4[0] = 8'h01; exp4[1] = 8'h02; exp4[2] = 8'h03;
    exp4[3] = 8'h04; exp4[4] = 8'h01; exp4[5] = 8'h02;
    exp_addr4 = 2'd2;
`else
    exp4[0] = 8'h01; exp4[1] = 8'h02; exp4[2] = 8'h03;
    exp4[3] = 8'h04; exp4[4] = 8'h04; exp4[5] = 8'h04;
    exp_addr4 = 2'd3;
`endif
    sck = 1'b0;
    cs = 1'b0;
    reset = 1'b1;
    #100;
    check_val("rst_cipo", cipo, 0);
    check_val("rst_addr", data_address, 0);
    check_val("rst_bit", bit_index, 0);
    check_val("rst_cnt", byte_count, 0);
    reset = 1'b0;
    #100;

    // Five bytes over 40 sck periods
    cs = 1'b1;
    for (int k = 0; k < 40; k++) begin
      clk_bit();
      if (k % 8 == 7) begin
        check_val("t1_byte", s_main, k / 8 + 1);
        check_val("t1_addr", data_address, (k + 1) / 8);
        check_val("t1_cnt", byte_count, (k + 1) / 8);
        check_val("t1_bit", bit_index, 0);
      end
    end
    cs = 1'b0;
    #10;
    check_val("t1_idle_cipo", cipo, 0);
    check_val("t1_idle_addr", data_address, 0);
    check_val("t1_idle_cnt", byte_count, 0);
    #100;

    // First bit valid before the first rising edge
    mem[0] = 8'hA5;
    #10 cs = 1'b1;
    #10;
    check_val("cs_rise_bit7", cipo, 1);
    clk_bit();
    check_val("bit6", cipo, 0);
    cs = 1'b0;
    #10;
    check_val("cs_low_cipo", cipo, 0);
    mem[0] = 8'h01;
    #100;

    // Abort after 12 bits, then a fresh byte
    cs = 1'b1;
    for (int k = 0; k < 12; k++) clk_bit();
    check_val("abort_bit", bit_index, 4);
    check_val("abort_addr_pre", data_address, 1);
    cs = 1'b0;
    #10;
    check_val("abort_addr", data_address, 0);
    check_val("abort_bitidx", bit_index, 0);
    check_val("abort_cnt", byte_count, 0);
    #100 cs = 1'b1;
    for (int k = 0; k < 8; k++) clk_bit();
    check_val("abort_byte", s_main, 8'h01);
    check_val("abort_cnt2", byte_count, 1);
    cs = 1'b0;
    #100;

    // Reset pulse mid-byte with cs held high
    cs = 1'b1;
    for (int k = 0; k < 11; k++) clk_bit();
    check_val("rstmid_bit_pre", bit_index, 3);
    reset = 1'b1;
    #10;
    check_val("rstmid_bit", bit_index, 0);
    check_val("rstmid_addr", data_address, 0);
    check_val("rstmid_cnt", byte_count, 0);
    check_val("rstmid_cipo", cipo, 0);
    #50 reset = 1'b0;
    #50;
    for (int k = 0; k < 8; k++) clk_bit();
    check_val("rstmid_byte", s_main, 8'h01);
    cs = 1'b0;
    #100;

    // cs and sck fall together: clear wins
    cs = 1'b1;
    for (int k = 0; k < 7; k++) clk_bit();
    #500 sck = 1'b1;
    #500;
    sck = 1'b0;
    cs = 1'b0;
    #1;
    check_val("simul_bit", bit_index, 0);
    check_val("simul_cnt", byte_count, 0);
    #100;

    // DEPTH=4 instance: six bytes across the end of memory
    cs = 1'b1;
    for (int k = 0; k < 48; k++) begin
      clk_bit();
      if (k % 8 == 7) check_val("d4_byte", s4, exp4[k / 8]);
    end
    check_val("d4_cnt", byte_count4, 6);
    check_val("d4_addr", data_address4, exp_addr4);
    cs = 1'b0;
    #10;
    check_val("d4_idle_addr", data_address4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
